// File: rtl/can_crc_if.sv
// can_crc_if: frame field code, transmitted bit and CRC results exchanged between transmit controller and CRC generator
interface can_crc_if;
  logic [5:0]  Estado;
  logic        Bit_Entrada;
  logic        Bit_Saida;
  logic [14:0] CRC_valor;
  logic        CRC_fim;
  logic        CRC_incompleto;
  modport master(output Estado, Bit_Entrada, input Bit_Saida, CRC_valor, CRC_fim, CRC_incompleto);
  modport slave(input Estado, Bit_Entrada, output Bit_Saida, CRC_valor, CRC_fim, CRC_incompleto);
endinterface

// File: rtl/can_crc_generator.sv
// can_crc_generator: CAN CRC-15 accumulate and MSB-first serialise; CAN_CRC_DELIM_EN adds a recessive delimiter bit before CRC_fim
module can_crc_generator #(
  parameter int CLKS_PER_BIT = 10
) (
  input logic     Clock_TB,
  input logic     Reset,
  can_crc_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef CAN_CRC_DELIM_EN
  typedef enum logic [2:0] {IDLE, ACUM, ENVIA, DELIM, FIM} state_t;
`else
  typedef enum logic [2:0] {IDLE, ACUM, ENVIA, FIM} state_t;
`endif
  state_t        state;
  logic [CW-1:0] Clock_Count;
  logic [14:0]   crc;
  logic [14:0]   crc_next;
  logic [3:0]    Count;
  logic          fim;
  logic          incompleto;
  logic          tick;
  logic          nxt;
  logic          sending;
  always_comb begin
    tick     = Clock_Count == CW'(CLKS_PER_BIT - 1);
    nxt      = bus.Bit_Entrada ^ crc[14];
    crc_next = {crc[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0000);
    sending  = bus.Estado == 6'd8 && (state == IDLE || state == ACUM || state == ENVIA);
  end
  assign bus.Bit_Saida      = sending ? crc[Count] : 1'b1;
  assign bus.CRC_valor      = crc;
  assign bus.CRC_fim        = fim;
  assign bus.CRC_incompleto = incompleto;
  always_ff @(posedge Clock_TB or posedge Reset) begin
    if (Reset) begin
      Clock_Count <= '0;
      crc         <= '0;
      Count       <= 4'd14;
      state       <= IDLE;
      fim         <= 1'b0;
      incompleto  <= 1'b0;
    end else begin
      Clock_Count <= tick ? '0 : Clock_Count + CW'(1);
      fim         <= 1'b0;
      if (tick) begin
        if (bus.Estado == 6'd17) begin
          crc        <= '0;
          Count      <= 4'd14;
          incompleto <= 1'b0;
          state      <= IDLE;
        end else begin
          case (state)
            IDLE, ACUM: begin
              if (bus.Estado < 6'd8) begin
                crc   <= crc_next;
                state <= ACUM;
              end else if (bus.Estado == 6'd8) begin
                Count <= 4'd13;
                state <= ENVIA;
              end
            end
            ENVIA: begin
              if (bus.Estado != 6'd8) begin
                incompleto <= 1'b1;
                state      <= FIM;
              end else if (Count == 4'd0) begin
`ifdef CAN_CRC_DELIM_EN
                state <= DELIM;
`else
                fim   <= 1'b1;
                state <= FIM;
`endif
              end else begin
                Count <= Count - 4'd1;
              end
            end
`ifdef CAN_CRC_DELIM_EN
            DELIM: begin
              fim        <= bus.Estado == 6'd8;
              incompleto <= bus.Estado != 6'd8;
              state      <= FIM;
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_can_crc_generator.sv
// tb_can_crc_generator: random frames checked against a polynomial long-division model of CAN CRC-15
module tb_can_crc_generator;
  localparam int N = 4;
`ifdef CAN_CRC_DELIM_EN
  localparam int FULL = 16;
`else
  localparam int FULL = 15;
`endif
  logic Clock_TB = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit d[$];
  logic [14:0] got;
  can_crc_if bus();
  can_crc_generator #(.CLKS_PER_BIT(N)) dut (.Clock_TB(Clock_TB), .Reset(Reset), .bus(bus));
  always #5 Clock_TB = ~Clock_TB;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [14:0] ref_crc(input bit msg[$]);
    bit m[$];
    logic [15:0] p = 16'hC599;
    logic [14:0] r = '0;
    m = msg;
    for (int i = 0; i < 15; i++) m.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (m[i]) for (int j = 0; j < 16; j++) m[i+j] ^= p[15-j];
    for (int i = msg.size(); i < m.size(); i++) r = {r[13:0], m[i]};
    return r;
  endfunction
  task automatic bit_time(input int e, input logic b, output logic so, output logic f);
    bus.Estado = 6'(e);
    bus.Bit_Entrada = b;
    #1 so = bus.Bit_Saida;
    for (int c = 0; c < N; c++) begin
      @(negedge Clock_TB);
      if (bus.CRC_fim) pulses++;
      @(posedge Clock_TB);
    end
    #1 f = bus.CRC_fim;
  endtask
  task automatic frame(input bit data[$], input int crc_bits, output logic [14:0] valor);
    bit sent[$];
    logic so, f;
    logic [14:0] exp;
    bit_time(17, 1'b0, so, f);
    pulses = 0;
    foreach (data[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        bit_time($urandom_range(9, 16), 1'($urandom), so, f);
        check("noncov_crc", bus.CRC_valor, ref_crc(sent));
      end
      bit_time($urandom_range(0, 7), data[i], so, f);
      check("cov_saida", so, 1);
      sent.push_back(data[i]);
      check("acc_crc", bus.CRC_valor, ref_crc(sent));
    end
    exp = ref_crc(sent);
    valor = bus.CRC_valor;
    for (int k = 0; k < crc_bits; k++) begin
      bit_time(8, 1'($urandom), so, f);
      check("crc_bit", so, k < 15 ? exp[14-k] : 1'b1);
      check("fim_at", f, k == FULL - 1);
      check("valor_frozen", bus.CRC_valor, exp);
    end
    if (crc_bits < FULL) begin
      bit_time(9, 1'b0, so, f);
      check("incompleto_set", bus.CRC_incompleto, 1);
      check("no_fim", f, 0);
    end else begin
      bit_time(8, 1'b0, so, f);
      check("fim_saida", so, 1);
      check("fim_incompleto", bus.CRC_incompleto, 0);
    end
    bit_time(17, 1'b0, so, f);
    check("fim_pulses", pulses, crc_bits >= FULL ? 1 : 0);
    check("clr_valor", bus.CRC_valor, 0);
    check("clr_incompleto", bus.CRC_incompleto, 0);
  endtask
  initial begin
    logic so, f;
    bus.Estado = 6'd17;
    bus.Bit_Entrada = 1'b0;
    repeat (3) @(posedge Clock_TB);
    #1 Reset = 1'b0;
    check("rst_saida", bus.Bit_Saida, 1);
    check("rst_valor", bus.CRC_valor, 0);
    check("rst_fim", bus.CRC_fim, 0);
    check("rst_incompleto", bus.CRC_incompleto, 0);
    repeat (3) begin
      bit_time(17, 1'b1, so, f);
      check("idle_saida", bus.Bit_Saida, 1);
      check("idle_valor", bus.CRC_valor, 0);
      check("idle_fim", f, 0);
    end
    d = {};
    d.push_back(1'b1);
    frame(d, FULL, got);
    check("crc_1", got, 15'h4599);
    d.push_back(1'b0);
    frame(d, FULL, got);
    check("crc_10", got, 15'h4EAB);
    d.delete();
    repeat (8) d.push_back(1'b0);
    frame(d, FULL, got);
    check("crc_zeros", got, 0);
    d.delete();
    frame(d, FULL, got);
    check("crc_empty", got, 0);
    repeat (10) d.push_back(1'($urandom));
    frame(d, 5, got);
    repeat (6) begin
      d.delete();
      repeat ($urandom_range(1, 40)) d.push_back(1'($urandom));
      frame(d, FULL, got);
    end
    bit_time(17, 1'b0, so, f);
    bit_time(2, 1'b1, so, f);
    bit_time(3, 1'b1, so, f);
    repeat (3) bit_time(8, 1'b0, so, f);
    bus.Estado = 6'd8;
    @(posedge Clock_TB);
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_valor", bus.CRC_valor, 0);
    check("mid_rst_fim", bus.CRC_fim, 0);
    check("mid_rst_incompleto", bus.CRC_incompleto, 0);
    bus.Estado = 6'd17;
    #1 check("mid_rst_saida", bus.Bit_Saida, 1);
    repeat (2) @(posedge Clock_TB);
    #1 Reset = 1'b0;
    d.delete();
    d.push_back(1'b1);
    frame(d, FULL, got);
    check("post_rst_crc", got, 15'h4599);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/can_crc_generator.md
# can_crc_generator

CRC-15 generator for the CAN transmit path, the transmit-side counterpart of the receive-side CRC check. It runs its own bit-time divider and tracks the frame field code `Estado` driven by the transmit controller. It accumulates the CAN CRC-15 over every transmitted bit of SOF through the data field (`Estado` 0..7). During the CRC field (`Estado`==8) it serialises the 15-bit result MSB first on `Bit_Saida`, which the transmitter muxes onto the bus.

## Interface
- `CLKS_PER_BIT`, default 10: system clocks per CAN bit; minimum 2.
- `Clock_TB`  in  1  system clock, all logic on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Estado`  in  6  current transmit frame field code: 0..7 = CRC-covered fields, 8 = CRC field, 17 = idle/interframe; other codes are non-covered fields.
- `Bit_Entrada`  in  1  bit currently being transmitted (unstuffed), stable for the whole bit time.
- `Bit_Saida`  out  1  CRC bit to transmit; 1 (recessive) when not sending.
- `CRC_valor`  out  15  current CRC register.
- `CRC_fim`  out  1  one-clock pulse when the CRC field (plus delimiter, see Configuration) is complete.
- `CRC_incompleto`  out  1  sticky: `Estado` left 8 before all CRC bits were sent.

## Operation
- Bit tick: `Clock_Count` counts 0..`CLKS_PER_BIT`-1. Tick is the clock where the count is `CLKS_PER_BIT`-1. The count wraps to 0 on the same edge. All state updates below happen only on a tick, sampling `Estado` and `Bit_Entrada`.
- Polynomial x^15+x^14+x^10+x^8+x^7+x^4+x^3+1 (0x4599).
  - Per covered bit: `nxt = Bit_Entrada ^ CRC[14]`, then `CRC = {CRC[13:0],0}`, then XOR 0x4599 if `nxt`.
  - Register is 15 bits; bit 15 is discarded.
- FSM states: IDLE, ACUM, ENVIA, DELIM (macro only), FIM.
  - Any state, tick with `Estado`==17: CRC=0, `Count`=14, `CRC_incompleto`=0, go to IDLE. This has priority over everything else.
  - IDLE/ACUM, tick with `Estado` 0..7: update CRC, go to ACUM.
  - IDLE/ACUM, tick with `Estado`==8: enter ENVIA and consume bit `Count`=14 on this tick (`Count` becomes 13). An empty frame sends CRC=0.
  - ENVIA, tick with `Estado`==8: `Count` decrements. On the tick consuming `Count`==0, go to FIM (or DELIM), and pulse `CRC_fim` if going to FIM.
  - ENVIA, tick with `Estado` not 8 and not 17: set `CRC_incompleto`, go to FIM, no `CRC_fim`.
  - FIM: holds until `Estado`==17. Covered codes 0..7 in FIM are ignored; the CRC stays frozen.
  - Other codes in IDLE/ACUM: no CRC update, state held.
- `Bit_Saida` is combinational:
  - `CRC[Count]` when `Estado`==8 and state is IDLE, ACUM or ENVIA;
  - 1 otherwise.
  - The first CRC bit is therefore valid as soon as `Estado` becomes 8, for the whole bit time.
- `CRC_valor` = CRC register, frozen from the first `Estado`==8 tick until clear.

## Timing
- Reset values: `Clock_Count`=0, CRC=0, `Count`=14, state IDLE, `Bit_Saida`=1, `CRC_valor`=0, `CRC_fim`=0, `CRC_incompleto`=0.
- Reset mid-frame aborts immediately. The divider restarts, so the first tick after reset release is `CLKS_PER_BIT` clocks later.
- CRC update latency: `CRC_valor` reflects a bit one clock after its tick edge.
- `Bit_Saida` steps to the next CRC bit on the clock after each ENVIA tick: combinational from the registered `Count` and the `Estado` input.
- `CRC_fim` is high for exactly one clock, the clock after the final tick.
- The CRC field lasts exactly 15 bit times (16 with the delimiter).

## Configuration
- `CAN_CRC_DELIM_EN` defined:
  - After the tick consuming bit 0, the state is DELIM.
  - `Bit_Saida`=1 for one more bit time while `Estado`==8.
  - `CRC_fim` pulses after that tick, and the state goes to FIM.
  - `Estado` not 8 during DELIM sets `CRC_incompleto`.
- Not defined: no DELIM state. `CRC_fim` pulses after the bit-0 tick, and the transmitter supplies the delimiter.

## Test plan
- Reset released, `Estado`=17 for 3 bit times → `Bit_Saida`=1, `CRC_valor`=0, `CRC_fim`=0.
- Covered bits "1", then `Estado`=8 → `CRC_valor`=0x4599 after the tick.
- Covered bits "1","0", then `Estado`=8 → `CRC_valor`=0x4EAB. `Bit_Saida` sequence 1,0,0,1,1,1,0,1,0,1,0,1,0,1,1 over 15 bit times; `CRC_fim` pulses once, 15 bit times after entering 8 (16 with `CAN_CRC_DELIM_EN`, last bit 1).
- 8 zero covered bits → `CRC_valor`=0, 15 zeros sent.
- `Estado` 8 → 9 after 5 CRC bits → `CRC_incompleto`=1, no `CRC_fim`; `Estado`=17 tick clears it.
- `Reset` asserted mid-ENVIA, released → all outputs at reset values; a new frame "1" yields 0x4599.
